// File: rtl/cpu_fetch_pkg.sv
// Shared types and default sizing for the sequential instruction fetch front end.
package cpu_fetch_pkg;

  localparam int unsigned DEFAULT_ADDR_W   = 2;
  localparam int unsigned DEFAULT_INSTR_W  = 2;
  localparam int unsigned DEFAULT_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-store address/data and the fetch-to-decode valid/ready slot.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned INSTR_W = 2
);

  logic [ADDR_W-1:0]  InstructionAddress;
  logic [INSTR_W-1:0] Instruction;
  logic               FetchValid;
  logic [INSTR_W-1:0] FetchInstr;
  logic [ADDR_W-1:0]  FetchPC;
  logic               FetchReady;

  modport master (
    output InstructionAddress,
    input  Instruction,
    output FetchValid,
    output FetchInstr,
    output FetchPC,
    input  FetchReady
  );

  modport slave (
    input  InstructionAddress,
    output Instruction,
    input  FetchValid,
    input  FetchInstr,
    input  FetchPC,
    output FetchReady
  );

endinterface

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register: load has priority over increment, wraps modulo 2^ADDR_W.
module program_counter
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: redirect beats sequential increment; carry out is dropped.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register with asynchronous reset to the boot address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential fetch front end: FSM, PC control and the single-entry output slot.
module instruction_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned INSTR_W  = DEFAULT_INSTR_W,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       Start,
  input  logic                       Halt,
  input  logic                       BranchValid,
  input  logic [ADDR_W-1:0]          BranchTarget,
  output logic                       Busy,
  instruction_fetch_unit_if.master   bus
);

  fetch_state_e       state_q, state_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic [INSTR_W-1:0] fetch_instr_q, fetch_instr_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;

  logic               pc_load;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc;
  logic               slot_free;
  logic               slot_taken;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .load_en  (pc_load),
    .load_val (BranchTarget),
    .inc_en   (pc_inc),
    .pc       (pc)
  );

  assign slot_taken = fetch_valid_q && bus.FetchReady;
  assign slot_free  = !fetch_valid_q || bus.FetchReady;

  // Next-state, slot update and PC control in priority order per state.
  always_comb begin
    state_d       = state_q;
    fetch_valid_d = fetch_valid_q;
    fetch_instr_d = fetch_instr_q;
    fetch_pc_d    = fetch_pc_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start && !Halt) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (BranchValid) begin
          pc_load       = 1'b1;
          fetch_valid_d = 1'b0;
        end else if (Halt) begin
          // A slot handed over on this same edge must not be presented twice.
          state_d = ST_HALTED;
          if (slot_taken) begin
            fetch_valid_d = 1'b0;
          end
        end else if (slot_free) begin
          fetch_instr_d = bus.Instruction;
          fetch_pc_d    = pc;
          fetch_valid_d = 1'b1;
          pc_inc        = 1'b1;
        end
      end
      ST_HALTED: begin
        pc_load = BranchValid;
        if (slot_taken) begin
          fetch_valid_d = 1'b0;
        end
        if (Start && !Halt) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output slot registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  assign bus.InstructionAddress = pc;
  assign bus.FetchValid         = fetch_valid_q;
  assign bus.FetchInstr         = fetch_instr_q;
  assign bus.FetchPC            = fetch_pc_q;
  assign Busy                   = (state_q == ST_FETCH);

endmodule
